// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator, STEP positions per clock, valid/ready on both sides.
// Rotate ops are built only when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int AWP = AW + 1;
    localparam logic [AW:0] STEP_C  = AWP'(STEP);
    localparam logic [AW:0] WIDTH_C = AWP'(WIDTH);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    rem_q, rem_d;

    logic [AW:0]      rem_x;
    logic [AW:0]      k;
    logic [AW:0]      kinv;
    logic [AW-1:0]    rem_nxt;
    logic [WIDTH-1:0] lsl, lsr, asr;
    logic [WIDTH-1:0] hi_out, lo_out;
    logic             illegal;

    // k never exceeds remaining, which is at most WIDTH-1
    assign rem_x   = {1'b0, rem_q};
    assign k       = (rem_x < STEP_C) ? rem_x : STEP_C;
    assign kinv    = WIDTH_C - k;
    assign rem_nxt = rem_q - k[AW-1:0];

    assign lsl    = data_q << k;
    assign lsr    = data_q >> k;
    assign asr    = $signed(data_q) >>> k;
    assign hi_out = data_q >> kinv;
    assign lo_out = data_q >> (k - AWP'(1));

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [WIDTH-1:0] rol, ror;
    assign rol     = lsl | (data_q >> kinv);
    assign ror     = lsr | (data_q << kinv);
    assign illegal = (in_op > 3'd5);
`else
    assign illegal = (in_op > 3'd3);
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        carry_d     = carry_q;
        err_d       = err_q;
        op_d        = op_q;
        rem_d       = rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_data;
                    op_d    = in_op;
                    rem_d   = in_amt;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    if (in_op == 3'd0 || in_amt == '0 || illegal) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        err_d       = illegal;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                rem_d = rem_nxt;
                case (op_q)
                    3'd1: begin
                        data_d  = lsl;
                        carry_d = hi_out[0];
                    end
                    3'd2: begin
                        data_d  = lsr;
                        carry_d = lo_out[0];
                    end
                    3'd3: begin
                        data_d  = asr;
                        carry_d = lo_out[0];
                    end
`ifdef SEQ_SHIFTER_ROTATE_EN
                    3'd4: begin
                        data_d  = rol;
                        carry_d = rol[0];
                    end
                    3'd5: begin
                        data_d  = ror;
                        carry_d = ror[WIDTH-1];
                    end
`endif
                    default: data_d = data_q;
                endcase
                if (rem_nxt == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            op_q        <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign out_err   = err_q;

endmodule
